mult_requester: RTL

MULT_REQUESTER -- requirements
Module: mult_requester

---
 rtl/mult_requester_if.sv | 32 +++
 rtl/mult_requester.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mult_requester_if.sv
// Handshake and datapath bundle between the requester, its producer/consumer
// and the multiplier controller. Signal names match the original ports.
interface mult_requester_if #(
  parameter int unsigned W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             start;
  logic [W-1:0]     opA;
  logic [W-1:0]     opB;
  logic             Done;
  logic [2*W-1:0]   result;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   out_data;
  logic             out_err;
  logic             busy;

  // Environment side: producer, multiplier controller and consumer
  modport master (
    output in_valid, in_a, in_b, Done, result, out_ready,
    input  in_ready, start, opA, opB, out_valid, out_data, out_err, busy
  );

  // Requester side
  modport slave (
    input  in_valid, in_a, in_b, Done, result, out_ready,
    output in_ready, start, opA, opB, out_valid, out_data, out_err, busy
  );
endinterface

// File: rtl/mult_requester.sv
// Multiplier requester: queues operand pairs in a 2-entry FIFO, issues one
// request at a time to the multiplier controller, guards it with a watchdog
// and holds the product (or a timeout flag) until the consumer takes it.
module mult_requester #(
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  mult_requester_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [W-1:0]     r_fifo_a [2];
  logic [W-1:0]     r_fifo_b [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;

  logic [7:0]       r_wdog;
  logic [W-1:0]     r_op_a;
  logic [W-1:0]     r_op_b;
  logic             r_out_valid;
  logic [2*W-1:0]   r_out_data;
  logic             r_out_err;

  logic             w_in_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_capture;
  logic             w_timeout;
  logic             w_start;
  logic             w_busy;
  logic             w_out_fire;

  // Input/output handshake qualifiers
  always_comb begin
    w_in_ready = (r_count < 2'd2) && !rst;
    w_push     = bus.in_valid && w_in_ready;
    w_out_fire = r_out_valid && bus.out_ready;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and control strobes; Done outside BUSY is ignored
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_start     = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_count != 2'd0) && (!r_out_valid || bus.out_ready)) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_start     = 1'b1;
        w_busy      = 1'b1;
        w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        w_busy = 1'b1;
        if (bus.Done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wdog == WDOG_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand FIFO; simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_fifo_a[0] <= '0;
      r_fifo_a[1] <= '0;
      r_fifo_b[0] <= '0;
      r_fifo_b[1] <= '0;
    end else begin
      if (w_push) begin
        r_fifo_a[r_wr_ptr] <= bus.in_a;
        r_fifo_b[r_wr_ptr] <= bus.in_b;
        r_wr_ptr           <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Watchdog: cleared while issuing, counts every BUSY cycle
  always_ff @(posedge clk) begin
    if (rst)                   r_wdog <= '0;
    else if (r_state == S_ISSUE) r_wdog <= '0;
    else if (r_state == S_BUSY)  r_wdog <= r_wdog + 8'd1;
  end

  // Operand registers loaded from the FIFO head on pop, stable until next pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a <= '0;
      r_op_b <= '0;
    end else if (w_pop) begin
      r_op_a <= r_fifo_a[r_rd_ptr];
      r_op_b <= r_fifo_b[r_rd_ptr];
    end
  end

  // Result holding register; a capture takes priority over a consumer accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.result;
      r_out_err   <= 1'b0;
    end else if (w_timeout) begin
      r_out_valid <= 1'b1;
      r_out_data  <= '0;
      r_out_err   <= 1'b1;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.start     = w_start;
  assign bus.busy      = w_busy;
  assign bus.opA       = r_op_a;
  assign bus.opB       = r_op_b;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_err   = r_out_err;

endmodule
